// File: rtl/head_table_lookup.sv
// Head-table lookup stage: reads the bucket head pointer for each hashed task and
// forwards snooped head-table writes into every in-flight and buffered task.
package head_table_lookup_pkg;
  localparam int unsigned KEY_WIDTH        = 16;
  localparam int unsigned VALUE_WIDTH      = 16;
  localparam int unsigned CMD_WIDTH        = 2;
  localparam int unsigned TABLE_ADDR_WIDTH = 8;
  localparam int unsigned BUCKET_WIDTH     = 8;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]    key;
    logic [VALUE_WIDTH-1:0]  value;
    logic [CMD_WIDTH-1:0]    cmd;
    logic [BUCKET_WIDTH-1:0] bucket;
  } hash_task_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]        key;
    logic [VALUE_WIDTH-1:0]      value;
    logic [CMD_WIDTH-1:0]        cmd;
    logic [BUCKET_WIDTH-1:0]     bucket;
    logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
    logic                        head_ptr_val;
  } ht_data_task_t;

  // fwd marks that a snooped write already supplied the head pointer
  typedef struct packed {
    logic          fwd;
    ht_data_task_t d;
  } shadow_t;
endpackage

module head_table_lookup
  import head_table_lookup_pkg::*;
#(
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned A_WIDTH     = TABLE_ADDR_WIDTH,
  parameter int unsigned B_WIDTH     = BUCKET_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  hash_task_t         task_i,
  input  logic               task_valid_i,
  output logic               task_ready_o,
  output logic [B_WIDTH-1:0] ht_rd_addr_o,
  output logic               ht_rd_en_o,
  input  logic [A_WIDTH-1:0] ht_rd_ptr_i,
  input  logic               ht_rd_ptr_val_i,
  input  logic [B_WIDTH-1:0] ht_wr_addr_i,
  input  logic [A_WIDTH-1:0] ht_wr_ptr_i,
  input  logic               ht_wr_ptr_val_i,
  input  logic               ht_wr_en_i,
  output ht_data_task_t      task_o,
  output logic               task_valid_o,
  input  logic               task_ready_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  function automatic shadow_t snoop_sh(input shadow_t s, input logic en,
                                       input logic [B_WIDTH-1:0] addr,
                                       input logic [A_WIDTH-1:0] ptr, input logic val);
    shadow_t r;
    r = s;
    if (en && (s.d.bucket == addr)) begin
      r.fwd            = 1'b1;
      r.d.head_ptr     = ptr;
      r.d.head_ptr_val = val;
    end
    return r;
  endfunction

  function automatic ht_data_task_t snoop_d(input ht_data_task_t e, input logic en,
                                            input logic [B_WIDTH-1:0] addr,
                                            input logic [A_WIDTH-1:0] ptr, input logic val);
    ht_data_task_t r;
    r = e;
    if (en && (e.bucket == addr)) begin
      r.head_ptr     = ptr;
      r.head_ptr_val = val;
    end
    return r;
  endfunction

  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ready;
  logic [RAM_LATENCY-1:0] r_pipe_vld;
  shadow_t                r_pipe [RAM_LATENCY];
  logic [CNT_W-1:0]       r_occ;
  logic                   r_out_valid;
  ht_data_task_t          r_fifo [FIFO_DEPTH];

  logic                   w_accept;
  logic                   w_pop;
  shadow_t                w_in;
  shadow_t                w_exit;
  ht_data_task_t          w_exit_d;
  logic                   w_exit_valid;
  logic [RAM_LATENCY-1:0] w_pipe_vld_nxt;
  shadow_t                w_pipe_nxt [RAM_LATENCY];
  ht_data_task_t          w_fifo_ext [FIFO_DEPTH+1];
  ht_data_task_t          w_fifo_nxt [FIFO_DEPTH];
  logic [CNT_W-1:0]       w_occ_popped;
  logic [CNT_W-1:0]       w_occ_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;

  assign w_accept     = task_valid_i & r_ready;
  assign w_pop        = r_out_valid & task_ready_i;
  assign ht_rd_en_o   = w_accept;
  assign ht_rd_addr_o = task_i.bucket;
  assign task_ready_o = r_ready;
  assign task_valid_o = r_out_valid;
  assign task_o       = r_fifo[0];

  // Shadow pipeline tracking the RAM read, with write snooping at every stage
  always_comb begin
    w_in                = '0;
    w_in.d.key          = task_i.key;
    w_in.d.value        = task_i.value;
    w_in.d.cmd          = task_i.cmd;
    w_in.d.bucket       = task_i.bucket;
    w_pipe_vld_nxt      = '0;
    w_pipe_vld_nxt[0]   = w_accept;
    w_pipe_nxt[0]       = snoop_sh(w_in, ht_wr_en_i, ht_wr_addr_i, ht_wr_ptr_i, ht_wr_ptr_val_i);
    for (int k = 1; k < int'(RAM_LATENCY); k++) begin
      w_pipe_vld_nxt[k] = r_pipe_vld[k-1];
      w_pipe_nxt[k]     = snoop_sh(r_pipe[k-1], ht_wr_en_i, ht_wr_addr_i, ht_wr_ptr_i,
                                   ht_wr_ptr_val_i);
    end
    w_exit       = snoop_sh(r_pipe[RAM_LATENCY-1], ht_wr_en_i, ht_wr_addr_i, ht_wr_ptr_i,
                            ht_wr_ptr_val_i);
    w_exit_valid = r_pipe_vld[RAM_LATENCY-1];
    w_exit_d     = w_exit.d;
    if (!w_exit.fwd) begin
      w_exit_d.head_ptr     = ht_rd_ptr_i;
      w_exit_d.head_ptr_val = ht_rd_ptr_val_i;
    end
  end

  // Shift-register FIFO: entry 0 is the presented head
  always_comb begin
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      w_fifo_ext[i] = r_fifo[i];
    end
    w_fifo_ext[FIFO_DEPTH] = '0;
    w_occ_popped = r_occ - CNT_W'(w_pop);
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      w_fifo_nxt[i] = snoop_d(w_pop ? w_fifo_ext[i+1] : w_fifo_ext[i], ht_wr_en_i,
                              ht_wr_addr_i, ht_wr_ptr_i, ht_wr_ptr_val_i);
      if (w_exit_valid && (CNT_W'(i) == w_occ_popped)) begin
        w_fifo_nxt[i] = w_exit_d;
      end
    end
    w_occ_nxt = w_occ_popped + CNT_W'(w_exit_valid);
    w_cnt_nxt = r_cnt + CNT_W'(w_accept) - CNT_W'(w_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt       <= '0;
      r_ready     <= 1'b1;
      r_pipe_vld  <= '0;
      r_occ       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_ready     <= (w_cnt_nxt < CNT_W'(FIFO_DEPTH));
      r_pipe_vld  <= w_pipe_vld_nxt;
      r_occ       <= w_occ_nxt;
      r_out_valid <= (w_occ_nxt != '0);
    end
  end

  // Payload storage needs no reset; validity lives in r_pipe_vld / r_occ
  always_ff @(posedge clk_i) begin
    r_pipe <= w_pipe_nxt;
    r_fifo <= w_fifo_nxt;
  end

endmodule

// File: tb/tb_head_table_lookup.sv
// Scoreboard bench for head_table_lookup: a behavioural head-table RAM plus a
// monitor that checks every output handshake against the current table contents.
module tb_head_table_lookup;
  import head_table_lookup_pkg::*;

  logic                        clk_i = 1'b0;
  logic                        rst_i;
  hash_task_t                  task_i;
  logic                        task_valid_i;
  logic                        task_ready_o;
  logic [BUCKET_WIDTH-1:0]     ht_rd_addr_o;
  logic                        ht_rd_en_o;
  logic [TABLE_ADDR_WIDTH-1:0] ht_rd_ptr_i;
  logic                        ht_rd_ptr_val_i;
  logic [BUCKET_WIDTH-1:0]     ht_wr_addr_i;
  logic [TABLE_ADDR_WIDTH-1:0] ht_wr_ptr_i;
  logic                        ht_wr_ptr_val_i;
  logic                        ht_wr_en_i;
  ht_data_task_t               task_o;
  logic                        task_valid_o;
  logic                        task_ready_i;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  hash_task_t exp_q [$];

  logic [TABLE_ADDR_WIDTH-1:0] mem_ptr [256];
  logic                        mem_val [256];
  logic [TABLE_ADDR_WIDTH-1:0] rd1_ptr, rd2_ptr;
  logic                        rd1_val, rd2_val;

  head_table_lookup #(.RAM_LATENCY(2), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .task_i(task_i), .task_valid_i(task_valid_i),
    .task_ready_o(task_ready_o), .ht_rd_addr_o(ht_rd_addr_o), .ht_rd_en_o(ht_rd_en_o),
    .ht_rd_ptr_i(ht_rd_ptr_i), .ht_rd_ptr_val_i(ht_rd_ptr_val_i),
    .ht_wr_addr_i(ht_wr_addr_i), .ht_wr_ptr_i(ht_wr_ptr_i),
    .ht_wr_ptr_val_i(ht_wr_ptr_val_i), .ht_wr_en_i(ht_wr_en_i),
    .task_o(task_o), .task_valid_o(task_valid_o), .task_ready_i(task_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Head-table RAM with a two-edge read latency; table is cleared while in reset
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 256; i++) begin
        mem_ptr[i] <= '0;
        mem_val[i] <= 1'b0;
      end
    end else if (ht_wr_en_i) begin
      mem_ptr[ht_wr_addr_i] <= ht_wr_ptr_i;
      mem_val[ht_wr_addr_i] <= ht_wr_ptr_val_i;
    end
    rd1_ptr <= mem_ptr[ht_rd_addr_o];
    rd1_val <= mem_val[ht_rd_addr_o];
    rd2_ptr <= rd1_ptr;
    rd2_val <= rd1_val;
  end
  assign ht_rd_ptr_i     = rd2_ptr;
  assign ht_rd_ptr_val_i = rd2_val;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard push on accept, pop and compare on output handshake
  always @(negedge clk_i) begin
    if (!rst_i) begin
      exp_q.delete();
    end else begin
      if (task_valid_i && task_ready_o) begin
        chk("rd_en_at_accept", 64'(ht_rd_en_o), 64'd1);
        chk("rd_addr", 64'(ht_rd_addr_o), 64'(task_i.bucket));
        exp_q.push_back(task_i);
      end else if (task_valid_i) begin
        chk("rd_en_when_full", 64'(ht_rd_en_o), 64'd0);
      end
      if (task_valid_o && task_ready_i) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          hash_task_t e;
          e = exp_q.pop_front();
          chk("out_task", 64'({task_o.key, task_o.value, task_o.cmd, task_o.bucket}), 64'(e));
          chk("out_head_ptr", 64'(task_o.head_ptr), 64'(mem_ptr[task_o.bucket]));
          chk("out_head_val", 64'(task_o.head_ptr_val), 64'(mem_val[task_o.bucket]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_task(input logic [15:0] k, input logic [7:0] b);
    task_i.key    = k;
    task_i.value  = ~k;
    task_i.cmd    = k[1:0];
    task_i.bucket = b;
  endtask

  // Presents a task until accepted; leaves task_valid_i high for back-to-back use
  task automatic send(input logic [15:0] k, input logic [7:0] b);
    int  n;
    logic ok;
    set_task(k, b);
    task_valid_i = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk_i);
      ok = task_ready_o;
      n++;
    end
    if (!ok) chk("send_timeout", 64'd1, 64'd0);
    tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] p, input logic v);
    ht_wr_addr_i    = a;
    ht_wr_ptr_i     = p;
    ht_wr_ptr_val_i = v;
    ht_wr_en_i      = 1'b1;
    tick();
    ht_wr_en_i      = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!task_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!task_valid_o) chk(name, 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    task_ready_i = 1'b1;
    while ((exp_q.size() != 0 || task_valid_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  task automatic do_reset();
    rst_i        = 1'b0;
    task_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
  endtask

  initial begin
    int lat;
    int acc;
    int sent;
    int cyc;
    int out0;
    logic acc_now;
    rst_i = 1'b0;
    task_i = '0;
    task_valid_i = 1'b0;
    task_ready_i = 1'b1;
    ht_wr_addr_i = '0;
    ht_wr_ptr_i = '0;
    ht_wr_ptr_val_i = 1'b0;
    ht_wr_en_i = 1'b0;
    do_reset();

    // 1: reset state, single lookup latency and data
    @(negedge clk_i);
    chk("reset_ready", 64'(task_ready_o), 64'd1);
    chk("reset_valid", 64'(task_valid_o), 64'd0);
    chk("reset_rd_en", 64'(ht_rd_en_o), 64'd0);
    tick();
    wr(8'h05, 8'h12, 1'b1);
    send(16'h1111, 8'h05);
    task_valid_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!task_valid_o && lat < 20);
    chk("latency", 64'(lat), 64'd3);
    chk("t1_head_ptr", 64'(task_o.head_ptr), 64'h12);
    chk("t1_head_val", 64'(task_o.head_ptr_val), 64'd1);
    drain();

    // 2: credit limit under backpressure
    task_ready_i = 1'b0;
    out0 = n_out;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      set_task(16'h2000 + 16'(acc), 8'(acc));
      task_valid_i = (acc < 6);
      @(negedge clk_i);
      if (task_valid_i && task_ready_o) acc++;
      tick();
    end
    task_valid_i = 1'b0;
    #1;
    chk("bp_accepted", 64'(acc), 64'd4);
    chk("bp_ready_low", 64'(task_ready_o), 64'd0);
    chk("bp_valid_high", 64'(task_valid_o), 64'd1);
    drain();
    chk("bp_outputs", 64'(n_out - out0), 64'd4);

    // 3: write to an empty bucket one cycle after the read
    send(16'h3333, 8'h07);
    task_valid_i = 1'b0;
    wr(8'h07, 8'h20, 1'b1);
    wait_valid("t3_no_output");
    chk("t3_head_ptr", 64'(task_o.head_ptr), 64'h20);
    chk("t3_head_val", 64'(task_o.head_ptr_val), 64'd1);
    drain();

    // 4: delete-style write while the head is stalled
    task_ready_i = 1'b0;
    send(16'h4444, 8'h07);
    task_valid_i = 1'b0;
    wait_valid("t4_no_output");
    chk("t4_pre_val", 64'(task_o.head_ptr_val), 64'd1);
    wr(8'h07, 8'h20, 1'b0);
    @(negedge clk_i);
    chk("t4_fwd_val", 64'(task_o.head_ptr_val), 64'd0);
    chk("t4_still_valid", 64'(task_valid_o), 64'd1);
    drain();

    // 5: random traffic, backpressure and snooped writes on a small bucket range
    sent = 0;
    cyc = 0;
    set_task(16'($urandom), 8'($urandom_range(0, 7)));
    while (sent < 100 && cyc < 3000) begin
      task_valid_i    = ($urandom_range(0, 3) != 0);
      task_ready_i    = ($urandom_range(0, 2) != 0);
      ht_wr_en_i      = ($urandom_range(0, 3) == 0);
      ht_wr_addr_i    = 8'($urandom_range(0, 7));
      ht_wr_ptr_i     = 8'($urandom);
      ht_wr_ptr_val_i = 1'($urandom);
      @(negedge clk_i);
      acc_now = task_valid_i & task_ready_o;
      tick();
      if (acc_now) begin
        sent++;
        set_task(16'($urandom), 8'($urandom_range(0, 7)));
      end
      cyc++;
    end
    task_valid_i = 1'b0;
    ht_wr_en_i   = 1'b0;
    chk("rand_sent", 64'(sent), 64'd100);
    drain();

    // 6: reset with reads in flight and entries buffered
    task_ready_i = 1'b0;
    send(16'h6001, 8'h01);
    send(16'h6002, 8'h02);
    task_valid_i = 1'b0;
    repeat (4) tick();
    send(16'h6003, 8'h03);
    send(16'h6004, 8'h04);
    rst_i = 1'b0;
    task_valid_i = 1'b0;
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_valid_low", 64'(task_valid_o), 64'd0);
    chk("rst_ready_high", 64'(task_ready_o), 64'd1);
    task_ready_i = 1'b1;
    out0 = n_out;
    repeat (10) tick();
    chk("rst_no_stale", 64'(n_out - out0), 64'd0);
    send(16'h6005, 8'h05);
    task_valid_i = 1'b0;
    drain();
    chk("rst_after_out", 64'(n_out - out0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
